// File: rtl/captura_adc_offset_if.sv
// captura_adc_offset_if: ADC-pin and sample-output signals of the capture stage
//  inicio  sample-rate tick requesting one conversion
//  sdata   ADC serial data
//  cs_n    ADC chip select, active low
//  sclk    ADC serial clock, idles high
//  Y       signed sample, held until the next valido
//  valido  one-cycle pulse when Y updates
//  perdido one-cycle pulse per inicio cycle that arrives while busy
//  master: environment side (tick source, ADC, filter bank); slave: capture stage
interface captura_adc_offset_if #(
  parameter int ancho = 23
);
  logic inicio;
  logic sdata;
  logic cs_n;
  logic sclk;
  logic [ancho-1:0] Y;
  logic valido;
  logic perdido;
  modport master (output inicio, sdata, input cs_n, sclk, Y, valido, perdido);
  modport slave (input inicio, sdata, output cs_n, sclk, Y, valido, perdido);
endinterface

// File: rtl/captura_adc_offset.sv
// captura_adc_offset: serial 12-bit offset-binary ADC capture, offset removal and scaling to the filter-bank format
//  clk    system clock, rising edge
//  reset  synchronous, active-low
//  bus    captura_adc_offset_if slave: inicio/sdata in; cs_n/sclk/Y/valido/perdido out (all registered)
module captura_adc_offset #(
  parameter int anchoentrada   = 12,
  parameter int ancho          = 23,
  parameter int desplazamiento = 10,
  parameter int DIV            = 2,
  parameter int QUIET          = 4
) (
  input logic clk,
  input logic reset,
  captura_adc_offset_if.slave bus
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int QW = QUIET > 2 ? $clog2(QUIET - 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_QUIET} state_t;
  state_t state_q, state_d;
  logic cs_n_q, cs_n_d;
  logic sclk_q, sclk_d;
  logic valido_q, valido_d;
  logic perdido_q, perdido_d;
  logic [ancho-1:0] y_q, y_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [3:0] bits_q, bits_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [anchoentrada-1:0] sh_q, sh_d;
  logic [anchoentrada-1:0] s;
  logic [ancho-1:0] y_new;
  // leading frame bits simply fall off the top of the shift register
  assign s = {~sh_q[anchoentrada-1], sh_q[anchoentrada-2:0]};
  assign y_new = ancho'($signed(s)) << desplazamiento;
  always_comb begin
    state_d = state_q;
    cs_n_d = cs_n_q;
    sclk_d = sclk_q;
    y_d = y_q;
    valido_d = 1'b0;
    perdido_d = bus.inicio && state_q != S_IDLE;
    dcnt_d = dcnt_q;
    bits_d = bits_q;
    qcnt_d = qcnt_q;
    sh_d = sh_q;
    case (state_q)
      S_IDLE: if (bus.inicio) state_d = S_CONV;
      // cs_n still high in CONV marks the one-cycle start slot before the first low phase
      S_CONV:
        if (cs_n_q) begin
          cs_n_d = 1'b0;
          sclk_d = 1'b0;
          dcnt_d = '0;
          bits_d = '0;
        end else if (dcnt_q != DW'(DIV - 1)) begin
          dcnt_d = dcnt_q + 1'b1;
        end else if (!sclk_q) begin
          dcnt_d = '0;
          sclk_d = 1'b1;
          sh_d = {sh_q[anchoentrada-2:0], bus.sdata};
        end else if (bits_q != 4'd15) begin
          dcnt_d = '0;
          sclk_d = 1'b0;
          bits_d = bits_q + 1'b1;
        end else begin
          dcnt_d = '0;
          cs_n_d = 1'b1;
          y_d = y_new;
          valido_d = 1'b1;
          qcnt_d = '0;
          state_d = QUIET > 1 ? S_QUIET : S_IDLE;
        end
      // the valido cycle already counts as the first quiet cycle
      S_QUIET:
        if (qcnt_q == QW'(QUIET - 2)) state_d = S_IDLE;
        else qcnt_d = qcnt_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b1;
      y_q <= '0;
      valido_q <= 1'b0;
      perdido_q <= 1'b0;
      dcnt_q <= '0;
      bits_q <= '0;
      qcnt_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      y_q <= y_d;
      valido_q <= valido_d;
      perdido_q <= perdido_d;
      dcnt_q <= dcnt_d;
      bits_q <= bits_d;
      qcnt_q <= qcnt_d;
      sh_q <= sh_d;
    end
  end
  assign bus.cs_n = cs_n_q;
  assign bus.sclk = sclk_q;
  assign bus.Y = y_q;
  assign bus.valido = valido_q;
  assign bus.perdido = perdido_q;
endmodule

// File: tb/tb_captura_adc_offset.sv
// tb_captura_adc_offset: directed frames against a cycle-level behavioural model of the capture stage
module tb_captura_adc_offset;
  localparam int DIV = 2;
  localparam int QUIET = 4;
  localparam int W = 23;
  localparam int FR = 1 + 32 * DIV;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] word = '0;
  int passed = 0;
  int total = 0;
  int nval = 0;
  int nperd = 0;
  int rises = 0;
  int cyc = 0;
  int ts = -1;
  int idx = 0;
  logic prev_sclk = 1'b1;
  logic [11:0] fd = '0;
  logic exp_cs_n = 1'b1;
  logic exp_sclk = 1'b1;
  logic exp_val = 1'b0;
  logic exp_perd = 1'b0;
  logic [W-1:0] exp_y = '0;
  captura_adc_offset_if #(.ancho(W)) bus ();
  captura_adc_offset #(
    .anchoentrada(12), .ancho(W), .desplazamiento(10), .DIV(DIV), .QUIET(QUIET)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] scale(input logic [11:0] d);
    int v;
    v = (int'(d) - 2048) * 1024;
    return v[W-1:0];
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, got, want);
  endtask
  // model: frame timing from the accepted start edge, Y from the offset-binary arithmetic
  always @(posedge clk) begin
    int k;
    bit busy;
    cyc++;
    if (!reset) begin
      ts = -1;
      exp_y = '0;
      exp_perd = 1'b0;
    end else begin
      busy = ts >= 0 && cyc > ts && cyc < ts + FR + QUIET;
      exp_perd = bus.inicio && busy;
      if (bus.inicio && !busy) begin
        ts = cyc;
        fd = word[11:0];
      end
    end
    k = ts < 0 ? -1 : cyc - ts;
    exp_cs_n = !(k >= 1 && k < FR);
    exp_sclk = !(k >= 1 && k < FR) || ((k - 1) / DIV) % 2 == 1;
    exp_val = k == FR;
    if (exp_val) exp_y = scale(fd);
  end
  always @(negedge clk) begin
    chk("cs_n", 32'(bus.cs_n), 32'(exp_cs_n));
    chk("sclk", 32'(bus.sclk), 32'(exp_sclk));
    chk("valido", 32'(bus.valido), 32'(exp_val));
    chk("perdido", 32'(bus.perdido), 32'(exp_perd));
    chk("Y", 32'(bus.Y), 32'(exp_y));
    if (bus.valido === 1'b1) nval++;
    if (bus.perdido === 1'b1) nperd++;
  end
  // ADC: presents the next frame bit after each sclk rise
  always @(negedge clk) begin
    if (bus.cs_n !== 1'b0) idx = 0;
    else if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
      idx++;
      rises++;
    end
    prev_sclk = bus.sclk;
    bus.sdata = idx < 16 ? word[4'(15 - idx)] : 1'b0;
  end
  task automatic start(input logic [3:0] lead, input logic [11:0] d);
    word = {lead, d};
    bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
  endtask
  task automatic wait_val(input int want);
    int lat;
    lat = 0;
    while (bus.valido !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(want));
  endtask
  task automatic frame(input logic [3:0] lead, input logic [11:0] d, input logic [W-1:0] want_y);
    start(lead, d);
    wait_val(FR);
    chk("Y_literal", 32'(bus.Y), 32'(want_y));
    repeat (QUIET) @(negedge clk);
  endtask
  initial begin
    int r0, n0, p0;
    bus.inicio = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(bus.cs_n), 32'd1);
    chk("rst_sclk", 32'(bus.sclk), 32'd1);
    chk("rst_Y", 32'(bus.Y), 32'd0);
    chk("rst_valido", 32'(bus.valido), 32'd0);
    chk("rst_perdido", 32'(bus.perdido), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    r0 = rises;
    frame(4'h0, 12'h800, 23'h000000);
    chk("sclk_rises", 32'(rises - r0), 32'd16);
    frame(4'h0, 12'hFFF, 23'h1FFC00);
    frame(4'h0, 12'h000, 23'h600000);
    frame(4'h0, 12'h7FF, 23'h7FFC00);
    n0 = nval;
    p0 = nperd;
    start(4'h0, 12'h0AB);
    repeat (19) @(negedge clk);
    bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    wait_val(FR - 20);
    chk("Y_busy", 32'(bus.Y), 32'h62AC00);
    repeat (2) @(negedge clk);
    bus.inicio = 1'b1;
    @(negedge clk);
    word = {4'h0, 12'h3C5};
    @(negedge clk);
    bus.inicio = 1'b0;
    wait_val(FR);
    chk("Y_back2back", 32'(bus.Y), 32'h6F1400);
    repeat (QUIET) @(negedge clk);
    chk("valido_count", 32'(nval - n0), 32'd2);
    chk("perdido_count", 32'(nperd - p0), 32'd2);
    n0 = nval;
    start(4'h0, 12'h555);
    repeat (31) @(negedge clk);
    chk("sclk_rise8", 32'(bus.sclk), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", 32'(bus.cs_n), 32'd1);
    chk("abort_valido", 32'(bus.valido), 32'd0);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    chk("abort_no_valido", 32'(nval - n0), 32'd0);
    chk("abort_Y", 32'(bus.Y), 32'd0);
    frame(4'hF, 12'h123, 23'h648C00);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
